// File: rtl/rt_avm_pkg.sv
// rt_avm_pkg: shared Avalon-MM widths and arbiter state encoding for the ray-tracer SDRAM path.
package rt_avm_pkg;
    localparam int AVM_AW  = 32;
    localparam int AVM_DW  = 16;
    localparam int AVM_BEW = 2;

    typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int nreq);
        return (int'(idx) == nreq - 1) ? 2'd0 : idx + 2'd1;
    endfunction
endpackage

// File: rtl/avm_id_fifo.sv
// avm_id_fifo: in-order queue of owner IDs for outstanding reads; push and pop may coincide even when full.
module avm_id_fifo #(
    parameter int IDW   = 1,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push_i,
    input  logic [IDW-1:0] push_id_i,
    input  logic           pop_i,
    output logic [IDW-1:0] head_o,
    output logic           full_o,
    output logic           empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [IDW-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q;

    assign head_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= push_id_i;
endmodule

// File: rtl/avm_master_arbiter.sv
// avm_master_arbiter: round-robin owner of the shared SDRAM Avalon-MM master port, routing each
// read response back to the requester that issued it, in issue order.
module avm_master_arbiter
    import rt_avm_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int MAX_PENDING = 8,
    parameter int MAX_HOLD    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_read,
    input  logic [NREQ-1:0]         req_write,
    input  logic [NREQ*AVM_AW-1:0]  req_address,
    input  logic [NREQ*AVM_DW-1:0]  req_writedata,
    input  logic [NREQ*AVM_BEW-1:0] req_byteenable,
    output logic [NREQ-1:0]         req_waitrequest,
    output logic [AVM_DW-1:0]       req_readdata,
    output logic [NREQ-1:0]         req_readdatavalid,
    output logic                    avm_m0_read,
    output logic                    avm_m0_write,
    output logic [AVM_AW-1:0]       avm_m0_address,
    output logic [AVM_DW-1:0]       avm_m0_writedata,
    output logic [AVM_BEW-1:0]      avm_m0_byteenable,
    input  logic                    avm_m0_waitrequest,
    input  logic [AVM_DW-1:0]       avm_m0_readdata,
    input  logic                    avm_m0_readdatavalid,
    output logic [1:0]              grant_idx,
    output logic                    busy,
    output logic                    err_orphan
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW  = $clog2(MAX_HOLD + 1);

    arb_state_e      state_q;
    logic [1:0]      grant_q, rr_q, pick;
    logic [HW-1:0]   hold_q, hold_d;
    logic            err_q;
    logic [NREQ-1:0] requesting, own_oh;
    logic            own_rd, own_wr, others, read_blocked, accept, release_grant;
    logic            fifo_full, fifo_empty, pop;
    logic [IDW-1:0]  head;

    assign requesting = req_read | req_write;

    // lowest requester overall, overridden by the lowest one at or after the RR pointer
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) if (requesting[i]) pick = 2'(i);
        for (int i = NREQ - 1; i >= 0; i--) if (requesting[i] && 2'(i) >= rr_q) pick = 2'(i);
    end

    always_comb begin
        own_oh            = '0;
        avm_m0_address    = '0;
        avm_m0_writedata  = '0;
        avm_m0_byteenable = '0;
        for (int i = 0; i < NREQ; i++) begin
            own_oh[i] = state_q == ARB_GRANTED && grant_q == 2'(i);
            if (own_oh[i]) begin
                avm_m0_address    = req_address[AVM_AW*i +: AVM_AW];
                avm_m0_writedata  = req_writedata[AVM_DW*i +: AVM_DW];
                avm_m0_byteenable = req_byteenable[AVM_BEW*i +: AVM_BEW];
            end
        end
    end

    assign own_rd  = |(req_read & own_oh);
    assign own_wr  = |(req_write & own_oh);
    assign others  = |(requesting & ~own_oh);

    // a read may enter a full tracker only when the head is popped in the same cycle
    assign pop           = avm_m0_readdatavalid && !fifo_empty;
    assign read_blocked  = own_rd && fifo_full && !pop;
    assign avm_m0_read   = own_rd && !read_blocked;
    assign avm_m0_write  = own_wr;
    assign accept        = (avm_m0_read || avm_m0_write) && !avm_m0_waitrequest;
    assign hold_d        = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);
    assign release_grant = state_q == ARB_GRANTED &&
                           (!(own_rd || own_wr) || (accept && hold_d == HW'(MAX_HOLD) && others));

    assign req_waitrequest = ~own_oh | {NREQ{avm_m0_waitrequest || read_blocked}};
    assign req_readdata    = avm_m0_readdata;

    always_comb begin
        req_readdatavalid = '0;
        for (int i = 0; i < NREQ; i++) req_readdatavalid[i] = pop && head == IDW'(i);
    end

    avm_id_fifo #(.IDW(IDW), .DEPTH(MAX_PENDING)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (accept && avm_m0_read),
        .push_id_i (grant_q[IDW-1:0]),
        .pop_i     (pop),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (avm_m0_readdatavalid && fifo_empty) err_q <= 1'b1;
            case (state_q)
                ARB_IDLE: if (|requesting) begin
                    state_q <= ARB_GRANTED;
                    grant_q <= pick;
                    hold_q  <= '0;
                end
                ARB_GRANTED: begin
                    if (accept) hold_q <= hold_d;
                    if (release_grant) begin
                        state_q <= ARB_IDLE;
                        rr_q    <= rr_next(grant_q, NREQ);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) if (!reset) assert (!(|(req_read & req_write)));

    assign grant_idx  = grant_q;
    assign busy       = state_q == ARB_GRANTED;
    assign err_orphan = err_q;
endmodule

// File: tb/tb_avm_master_arbiter.sv
// tb_avm_master_arbiter: directed checks of grant order, hold limit, read tracking and orphan detection.
module tb_avm_master_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  req_read, req_write, req_waitrequest, req_readdatavalid;
    logic [63:0] req_address;
    logic [31:0] req_writedata;
    logic [3:0]  req_byteenable;
    logic [15:0] req_readdata;
    logic        avm_m0_read, avm_m0_write, avm_m0_waitrequest;
    logic [31:0] avm_m0_address;
    logic [15:0] avm_m0_writedata;
    logic [1:0]  avm_m0_byteenable;
    logic [1:0]  grant_idx;
    logic        busy, err_orphan;

    int          acc0 = 0, acc1 = 0, tgt0 = 0, tgt1 = 0;
    logic [1:0]  is_wr = 2'b00;
    logic        slv_wait = 1'b0, hold_rsp = 1'b0, inject = 1'b0;
    logic        s_rdv = 1'b0;
    logic [15:0] s_rdata = '0, last_wdata = '0;
    int          cyc = 0, wr_cnt = 0;
    logic [15:0] rq_dat[$];
    int          rq_due[$];
    logic [15:0] got0[$], got1[$];
    int          n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    // requester models: each keeps issuing until its accepted count reaches its target
    assign req_read       = {acc1 < tgt1 && !is_wr[1], acc0 < tgt0 && !is_wr[0]};
    assign req_write      = {acc1 < tgt1 && is_wr[1], acc0 < tgt0 && is_wr[0]};
    assign req_address    = {32'h200 + 32'(acc1), 32'h100 + 32'(acc0)};
    assign req_writedata  = {16'hA000 + 16'(acc1), 16'hA000 + 16'(acc0)};
    assign req_byteenable = {2'b10, 2'b11};
    assign avm_m0_waitrequest = slv_wait;

    always @(posedge clk) begin
        if ((req_read[0] || req_write[0]) && !req_waitrequest[0]) acc0 <= acc0 + 1;
        if ((req_read[1] || req_write[1]) && !req_waitrequest[1]) acc1 <= acc1 + 1;
    end

    // slave: returns the low address half as read data, 3 cycles after acceptance
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (inject) begin
            s_rdv   <= 1'b1;
            s_rdata <= 16'hBEEF;
        end else if (!hold_rsp && rq_dat.size() > 0 && rq_due[0] <= cyc) begin
            s_rdv   <= 1'b1;
            s_rdata <= rq_dat.pop_front();
            void'(rq_due.pop_front());
        end else s_rdv <= 1'b0;
        if (avm_m0_read && !avm_m0_waitrequest) begin
            rq_dat.push_back(avm_m0_address[15:0]);
            rq_due.push_back(cyc + 3);
        end
        if (avm_m0_write && !avm_m0_waitrequest) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= avm_m0_writedata;
        end
    end

    always @(posedge clk) begin
        if (req_readdatavalid[0]) got0.push_back(req_readdata);
        if (req_readdatavalid[1]) got1.push_back(req_readdata);
    end

    avm_master_arbiter #(.NREQ(2), .MAX_PENDING(8), .MAX_HOLD(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_read             (req_read),
        .req_write            (req_write),
        .req_address          (req_address),
        .req_writedata        (req_writedata),
        .req_byteenable       (req_byteenable),
        .req_waitrequest      (req_waitrequest),
        .req_readdata         (req_readdata),
        .req_readdatavalid    (req_readdatavalid),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_readdata      (s_rdata),
        .avm_m0_readdatavalid (s_rdv),
        .grant_idx            (grant_idx),
        .busy                 (busy),
        .err_orphan           (err_orphan)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_read", avm_m0_read, 0);
        check("rst_write", avm_m0_write, 0);
        check("rst_addr", avm_m0_address, 0);
        check("rst_wreq", req_waitrequest, 2'b11);
        check("rst_rvalid", req_readdatavalid, 0);
        check("rst_err", err_orphan, 0);
        // single requester, 7 reads
        reset = 1'b0;
        tgt0 = 7;
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_grant", grant_idx, 0);
        check("t1_wreq", req_waitrequest, 2'b10);
        for (int t = 0; t < 60 && got0.size() < 7; t++) @(negedge clk);
        check("t1_rv0", got0.size(), 7);
        check("t1_rv1", got1.size(), 0);
        check("t1_idle", busy, 0);
        // simultaneous requests after reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tgt0 = 10;
        tgt1 = 3;
        @(negedge clk);
        check("t2_grant0", grant_idx, 0);
        check("t2_wreq", req_waitrequest, 2'b10);
        repeat (3) @(negedge clk);
        check("t2_acc0", acc0, 10);
        @(negedge clk);
        check("t2_release", busy, 0);
        @(negedge clk);
        check("t2_busy1", busy, 1);
        check("t2_grant1", grant_idx, 1);
        for (int t = 0; t < 60 && (got0.size() < 10 || got1.size() < 3); t++) @(negedge clk);
        check("t2_rv0", got0.size(), 10);
        check("t2_rv1", got1.size(), 3);
        // hold limit: 40 reads from req 0 with req 1 waiting
        tgt0 = 50;
        tgt1 = 7;
        repeat (17) @(negedge clk);
        check("t3_acc0_switch", acc0, 26);
        check("t3_release", busy, 0);
        check("t3_acc1_before", acc1, 3);
        @(negedge clk);
        check("t3_grant1", grant_idx, 1);
        check("t3_busy1", busy, 1);
        for (int t = 0; t < 200 && (got0.size() < 50 || got1.size() < 7); t++) @(negedge clk);
        check("t3_rv0", got0.size(), 50);
        check("t3_rv1", got1.size(), 7);
        for (int k = 0; k < got1.size(); k++) check("rd1_order", got1[k], 32'h200 + k);
        // tracker full: responses withheld, 9 reads
        hold_rsp = 1'b1;
        tgt0 = 59;
        repeat (9) @(negedge clk);
        check("t4_acc0_8", acc0, 58);
        check("t4_blocked", req_waitrequest[0], 1);
        check("t4_read_off", avm_m0_read, 0);
        check("t4_cnt_full", dut.u_fifo.cnt_q, 8);
        repeat (3) @(negedge clk);
        check("t4_still_58", acc0, 58);
        check("t4_hold_grant", busy, 1);
        hold_rsp = 1'b0;
        @(negedge clk);
        check("t4_unblocked", req_waitrequest[0], 0);
        check("t4_rvalid", req_readdatavalid, 2'b01);
        @(negedge clk);
        check("t4_cnt_pushpop", dut.u_fifo.cnt_q, 8);
        check("t4_acc0_9", acc0, 59);
        for (int t = 0; t < 60 && got0.size() < 59; t++) @(negedge clk);
        check("t4_rv0", got0.size(), 59);
        check("t4_cnt_empty", dut.u_fifo.cnt_q, 0);
        for (int k = 0; k < got0.size(); k++) check("rd0_order", got0[k], 32'h100 + k);
        // posted writes with a stalled slave
        is_wr[1] = 1'b1;
        slv_wait = 1'b1;
        tgt1 = 9;
        @(negedge clk);
        check("t5_grant1", grant_idx, 1);
        check("t5_write", avm_m0_write, 1);
        check("t5_read", avm_m0_read, 0);
        check("t5_addr", avm_m0_address, 32'h207);
        check("t5_wdata", avm_m0_writedata, 16'hA007);
        check("t5_be", avm_m0_byteenable, 2'b10);
        check("t5_wreq", req_waitrequest, 2'b11);
        @(negedge clk);
        check("t5_stall_acc", acc1, 7);
        check("t5_stall_busy", busy, 1);
        slv_wait = 1'b0;
        for (int t = 0; t < 20 && acc1 < 9; t++) @(negedge clk);
        @(negedge clk);
        check("t5_wr_cnt", wr_cnt, 2);
        check("t5_last_wdata", last_wdata, 16'hA008);
        check("t5_no_rv", got1.size(), 7);
        // orphan response with nothing outstanding
        is_wr[1] = 1'b0;
        check("t6_err_before", err_orphan, 0);
        inject = 1'b1;
        @(negedge clk);
        check("t6_no_rvalid", req_readdatavalid, 0);
        inject = 1'b0;
        @(negedge clk);
        check("t6_err", err_orphan, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t6_err_cleared", err_orphan, 0);
        check("t6_wreq", req_waitrequest, 2'b11);
        // reset in the middle of a read burst
        tgt0 = acc0 + 5;
        repeat (3) @(negedge clk);
        check("t7_acc0", acc0, 61);
        tgt0 = acc0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t7_no_rvalid", req_readdatavalid, 0);
        repeat (5) @(negedge clk);
        check("t7_err", err_orphan, 1);
        check("t7_rv0", got0.size(), 59);
        check("t7_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
